// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//   Programmable SPI serial-clock generator for the SPI master datapath.
//   Divides clk_i by 2*(div_i+1) to produce spi_clk_o with a selectable idle
//   level (CPOL). It also emits single-cycle rise/fall strobes that the
//   shift/sample logic uses as edge enables. Fully synchronous to clk_i.
//
// Ports
//   clk_i       in   system clock, all logic on posedge
//   rst_i       in   synchronous active-high reset
//   clk_en_i    in   1 = generate SCK, 0 = hold SCK at its idle level
//   div_i       in   half-period = div_i+1 clk_i cycles (sampled at reload)
//   cpol_i      in   SCK idle level (only followed while idle)
//   cpha_i      in   1 = first edge after one half-period,
//                    0 = one extra half-period of lead-in before the first edge
//   spi_clk_o   out  registered serial clock
//   spi_rise_o  out  high in the cycle spi_clk_o first reads 1 after a rise
//   spi_fall_o  out  high in the cycle spi_clk_o first reads 0 after a fall
//
// Configuration macro
//   SPI_CLKGEN_GRACEFUL_STOP_EN
//     defined  : dropping clk_en_i while SCK is away from its idle level lets
//                the current half-period finish; the scheduled edge (with its
//                strobe) brings SCK back to idle. clk_en_i is ignored until
//                that wind-down completes.
//     undefined: dropping clk_en_i forces SCK idle on the next posedge with no
//                strobe.
// -----------------------------------------------------------------------------
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  output logic             spi_clk_o,
  output logic             spi_rise_o,
  output logic             spi_fall_o
);

  // Half-period down-counter, lead-in flag, SCK and strobes
  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic             lead_q, lead_d;
  logic             sck_q,  sck_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  // Remembers whether the previous cycle was actively generating, so the
  // first enabled cycle can be recognised and the lead-in latched from cpha_i.
  logic             en_q,   en_d;

`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
  // Idle level captured while idle, and a flag marking an ongoing wind-down.
  logic             cpol_q, cpol_d;
  logic             stop_q, stop_d;
`endif

  logic             first;
  logic             wind;
  logic             lead_eff;
  logic             toggle;

  // Next-state logic. Idle reloads the counter from div_i and parks SCK at
  // cpol_i every cycle; running counts down and toggles SCK when the counter
  // expires, unless the lead-in half-period is still being consumed.
  always_comb begin
    first = clk_en_i & ~en_q;
`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
    // Keep running past clk_en_i=0 until SCK is back at its idle level.
    wind  = stop_q | (~clk_en_i & (sck_q ^ cpol_q));
`else
    wind  = 1'b0;
`endif
    // On the first enabled cycle the lead-in comes straight from cpha_i,
    // so that div_i=0 with cpha_i=0 still gets its extra half-period.
    lead_eff = (first & ~wind) ? ~cpha_i : lead_q;

    cnt_d  = cnt_q;
    lead_d = lead_q;
    sck_d  = sck_q;
    en_d   = 1'b0;
    toggle = 1'b0;
`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
    cpol_d = cpol_q;
    stop_d = 1'b0;
`endif

    if (!clk_en_i && !wind) begin
      cnt_d  = div_i;
      lead_d = 1'b0;
      sck_d  = cpol_i;
`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
      cpol_d = cpol_i;
`endif
    end else begin
      // During wind-down en stays low so a re-enable after it looks fresh.
      en_d = ~wind;
      if (cnt_q != '0) begin
        cnt_d  = cnt_q - DIV_W'(1);
        lead_d = lead_eff;
      end else begin
        cnt_d  = div_i;
        lead_d = 1'b0;
        if (!lead_eff) begin
          toggle = 1'b1;
          sck_d  = ~sck_q;
        end
      end
`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
      stop_d = wind & ~toggle;
`endif
    end

    rise_d = toggle &  sck_d;
    fall_d = toggle & ~sck_d;
  end

  // State registers with synchronous reset into the idle condition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= div_i;
      lead_q <= 1'b0;
      sck_q  <= cpol_i;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      en_q   <= 1'b0;
`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
      cpol_q <= cpol_i;
      stop_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      lead_q <= lead_d;
      sck_q  <= sck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      en_q   <= en_d;
`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
      cpol_q <= cpol_d;
      stop_q <= stop_d;
`endif
    end
  end

  assign spi_clk_o  = sck_q;
  assign spi_rise_o = rise_q;
  assign spi_fall_o = fall_q;

endmodule

// File: tb/tb_spi_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_clk_gen
//   Self-checking bench for spi_clk_gen. Every cycle the DUT outputs are
//   compared with a cycle-count reference model; fixed vector tables and a few
//   hand-written sequences add independent expected values.
// -----------------------------------------------------------------------------
module tb_spi_clk_gen;

`ifdef SPI_CLKGEN_GRACEFUL_STOP_EN
  localparam bit GRACEFUL = 1'b1;
`else
  localparam bit GRACEFUL = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clk_en_i;
  logic [7:0] div_i;
  logic       cpol_i;
  logic       cpha_i;
  logic       spi_clk_o;
  logic       spi_rise_o;
  logic       spi_fall_o;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining cycles in the current half-period, how many
  // half-periods are still to be skipped before the first edge, and whether
  // the generator is running or winding down.
  bit m_clk, m_rise, m_fall, m_run, m_cpol, m_stop;
  int m_left, m_skip;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       cpol;
    logic       cpha;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  spi_clk_gen #(.DIV_W(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clk_en_i   (clk_en_i),
    .div_i      (div_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .spi_clk_o  (spi_clk_o),
    .spi_rise_o (spi_rise_o),
    .spi_fall_o (spi_fall_o)
  );

  // 100 MHz system clock
  always #5 clk_i = ~clk_i;

  // Compare DUT {clk, rise, fall} against an expected triple
  task automatic checkOutput(input string name, input logic [2:0] exp);
    logic [2:0] act;
    act = {spi_clk_o, spi_rise_o, spi_fall_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: clk/rise/fall got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock using the inputs of that edge
  task automatic model_step();
    bit wind;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst_i) begin
      m_clk = cpol_i; m_left = int'(div_i) + 1; m_skip = 0;
      m_run = 1'b0; m_cpol = cpol_i; m_stop = 1'b0;
    end else begin
      wind = GRACEFUL && (m_stop || (!clk_en_i && (m_clk != m_cpol)));
      if (!clk_en_i && !wind) begin
        m_clk = cpol_i; m_left = int'(div_i) + 1; m_skip = 0;
        m_run = 1'b0; m_cpol = cpol_i; m_stop = 1'b0;
      end else begin
        if (!m_run && !wind) m_skip = cpha_i ? 0 : 1;
        m_run = !wind;
        m_left = m_left - 1;
        m_stop = wind;
        if (m_left == 0) begin
          m_left = int'(div_i) + 1;
          if (m_skip > 0) begin
            m_skip = m_skip - 1;
          end else begin
            m_clk  = !m_clk;
            m_rise = m_clk;
            m_fall = !m_clk;
            m_stop = 1'b0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, and check against the model
  task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] div,
                               input logic cpol, input logic cpha);
    rst_i = rst; clk_en_i = en; div_i = div; cpol_i = cpol; cpha_i = cpha;
    @(posedge clk_i);
    model_step();
    #1;
    checkOutput("model", {m_clk, m_rise, m_fall});
  endtask

  task automatic addVec(input logic rst, input logic en, input logic [7:0] div,
                        input logic cpol, input logic cpha, input logic [2:0] exp);
    vec_t v;
    v.rst = rst; v.en = en; v.div = div; v.cpol = cpol; v.cpha = cpha; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Reset followed by len enabled cycles; SCK toggles at enabled cycle
  // `first_edge` and every `half` cycles after that.
  task automatic addRun(input logic [7:0] div, input logic cpol, input logic cpha,
                        input int first_edge, input int half, input int len);
    int  n;
    bit  tog;
    logic c;
    addVec(1'b1, 1'b0, div, cpol, cpha, {cpol, 2'b00});
    for (int e = 1; e <= len; e++) begin
      n   = (e >= first_edge) ? (e - first_edge) / half + 1 : 0;
      tog = (e >= first_edge) && ((e - first_edge) % half == 0);
      c   = cpol ^ n[0];
      addVec(1'b0, 1'b1, div, cpol, cpha, {c, tog & c, tog & ~c});
    end
  endtask

  logic [2:0] exp6 [5:12];

  initial begin
    // Vector tables
    addVec(1'b1, 1'b0, 8'd7, 1'b1, 1'b0, 3'b100);
    for (int i = 0; i < 200; i++) addVec(1'b0, 1'b0, 8'($urandom), 1'b1, 1'($urandom), 3'b100);
    addRun(8'd3, 1'b1, 1'b1, 4, 4, 1000);
    addRun(8'd0, 1'b0, 1'b1, 1, 1, 16);
    addRun(8'd2, 1'b0, 1'b0, 6, 3, 15);
    addRun(8'd0, 1'b1, 1'b0, 2, 1, 8);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].div, vecs[i].cpol, vecs[i].cpha);
      checkOutput("table", vecs[i].exp);
    end

    // div_i 3 -> 1 in the middle of a half-period, then reset mid-run
    begin
      logic [2:0] exp5 [1:14];
      exp5 = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b100, 3'b100, 3'b100,
               3'b001, 3'b000, 3'b110, 3'b100, 3'b001, 3'b000, 3'b110};
      applyStimulus(1'b1, 1'b0, 8'd3, 1'b0, 1'b1);
      for (int e = 1; e <= 14; e++) begin
        applyStimulus(1'b0, 1'b1, (e >= 6) ? 8'd1 : 8'd3, 1'b0, 1'b1);
        checkOutput("div_change", exp5[e]);
      end
      applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
      checkOutput("mid_reset", 3'b000);
    end

    // Drop clk_en_i while SCK is high (cpol=0), re-enable two cycles later
    if (GRACEFUL) exp6 = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b110};
    else          exp6 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b100, 3'b100};
    applyStimulus(1'b1, 1'b0, 8'd3, 1'b0, 1'b1);
    for (int e = 1; e <= 4; e++) applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 1'b1);
    checkOutput("pre_stop", 3'b110);
    for (int e = 5; e <= 12; e++) begin
      applyStimulus(1'b0, (e >= 7), 8'd3, 1'b0, 1'b1);
      checkOutput("stop", exp6[e]);
    end

    // Largest divider: half-period of 256 cycles
    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    for (int e = 1; e <= 256; e++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
      if (e == 255) checkOutput("div_ff_before", 3'b000);
      if (e == 256) checkOutput("div_ff_edge", 3'b110);
    end

    // Randomised traffic against the model
    begin
      logic       en, cp, ch;
      logic [7:0] dv;
      en = 1'b1; dv = 8'd2;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 49) == 0) en = ~en;
        if ($urandom_range(0, 19) == 0) dv = 8'($urandom_range(0, 5));
        cp = 1'($urandom);
        ch = 1'($urandom);
        applyStimulus(($urandom_range(0, 499) == 0), en, dv, cp, ch);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
